// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
//  Module      : instruction_fetch_pkg
//  Description : Shared defaults, HALT encoding and next-PC selection helper
//                for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CLEAR
`define CLEAR(n) {(n){1'b0}}
`endif

package instruction_fetch_pkg;

    localparam int          DEFAULT_PC_SIZE               = 32;
    localparam int          DEFAULT_INSTRUCTION_SIZE      = 32;
    localparam int          DEFAULT_INSTRUCTION_MEM_WORDS = 256;
    localparam logic [31:0] INSTRUCTION_HALT              = 32'hFFFF_FFFF;

    // Source of the next program counter value
    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_REDIRECT = 2'd1,
        PC_SEL_SEQ      = 2'd2
    } pc_sel_e;

    // Stall beats redirect, redirect beats a fetched HALT; a frozen pipeline holds
    function automatic pc_sel_e select_next_pc(
        input logic enable,
        input logic stall,
        input logic not_seq,
        input logic halt
    );
        pc_sel_e sel;
        sel = PC_SEL_HOLD;
        if (enable) begin
            if (stall)        sel = PC_SEL_HOLD;
            else if (not_seq) sel = PC_SEL_REDIRECT;
            else if (halt)    sel = PC_SEL_HOLD;
            else              sel = PC_SEL_SEQ;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_memory.sv
// ============================================================================
//  Module      : instruction_memory
//  Description : Byte-addressed instruction store with a sequential loader
//                port, one-cycle clear and a 4-byte big-endian fetch read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_memory
    import instruction_fetch_pkg::*;
#(
    parameter int PC_SIZE           = DEFAULT_PC_SIZE,
    parameter int INSTRUCTION_SIZE  = DEFAULT_INSTRUCTION_SIZE,
    parameter int MEM_SIZE_IN_WORDS = DEFAULT_INSTRUCTION_MEM_WORDS
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_mem_write,
    input  logic [7:0]                  i_mem_data,
    input  logic                        i_mem_clear,
    input  logic [PC_SIZE-1:0]          i_addr,
    output logic [INSTRUCTION_SIZE-1:0] o_instruction,
    output logic                        o_mem_full,
    output logic                        o_mem_empty
);

    localparam int BYTES  = 4 * MEM_SIZE_IN_WORDS;
    localparam int ADDR_W = $clog2(BYTES);
    localparam int PTR_W  = ADDR_W + 1;   // one extra bit so "full" does not wrap to 0

    logic [7:0]        mem_q [0:BYTES-1];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic              w_write_accept;
    logic [PC_SIZE:0]  w_last_byte;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_base;

    assign o_mem_full     = (wr_ptr_q == PTR_W'(BYTES));
    assign o_mem_empty    = (wr_ptr_q == `CLEAR(PTR_W));
    // Loader owns the memory only while the pipeline is frozen; clear takes precedence
    assign w_write_accept = i_mem_write && !i_enable && !o_mem_full && !i_mem_clear;

    // Write pointer: rewind on clear, advance on each accepted byte
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (i_mem_clear)         wr_ptr_d = `CLEAR(PTR_W);
        else if (w_write_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    // Pointer register; reset rewinds it
    always_ff @(posedge i_clk) begin
        if (i_reset) wr_ptr_q <= `CLEAR(PTR_W);
        else         wr_ptr_q <= wr_ptr_d;
    end

    // Byte array; deliberately untouched by reset so a loaded program survives it
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (i_mem_clear) begin
                for (int i = 0; i < BYTES; i++) mem_q[i] <= 8'hFF;
            end else if (w_write_accept) begin
                mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_mem_data;
            end
        end
    end

    // Big-endian 4-byte read; a fetch running past the last byte yields HALT
    always_comb begin
        w_last_byte   = {1'b0, i_addr} + (PC_SIZE + 1)'(3);
        w_in_range    = (w_last_byte < (PC_SIZE + 1)'(BYTES));
        w_base        = i_addr[ADDR_W-1:0];
        o_instruction = INSTRUCTION_SIZE'(INSTRUCTION_HALT);
        if (w_in_range) begin
            o_instruction = INSTRUCTION_SIZE'({mem_q[w_base],
                                               mem_q[w_base + ADDR_W'(1)],
                                               mem_q[w_base + ADDR_W'(2)],
                                               mem_q[w_base + ADDR_W'(3)]});
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  Module      : instruction_fetch
//  Description : MIPS IF stage - program counter, next-PC priority selection
//                and the instruction memory feeding the IF/ID register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PC_SIZE           = DEFAULT_PC_SIZE,
    parameter int INSTRUCTION_SIZE  = DEFAULT_INSTRUCTION_SIZE,
    parameter int MEM_SIZE_IN_WORDS = DEFAULT_INSTRUCTION_MEM_WORDS
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_stall,
    input  logic                        i_not_seq,
    input  logic [PC_SIZE-1:0]          i_next_not_seq_pc,
    input  logic                        i_mem_write,
    input  logic [7:0]                  i_mem_data,
    input  logic                        i_mem_clear,
    output logic [PC_SIZE-1:0]          o_next_seq_pc,
    output logic [INSTRUCTION_SIZE-1:0] o_instruction,
    output logic                        o_halt,
    output logic                        o_mem_full,
    output logic                        o_mem_empty
);

    logic [PC_SIZE-1:0] pc_q;
    logic [PC_SIZE-1:0] pc_d;
    pc_sel_e            w_pc_sel;

    instruction_memory #(
        .PC_SIZE           (PC_SIZE),
        .INSTRUCTION_SIZE  (INSTRUCTION_SIZE),
        .MEM_SIZE_IN_WORDS (MEM_SIZE_IN_WORDS)
    ) u_instruction_memory (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_mem_write   (i_mem_write),
        .i_mem_data    (i_mem_data),
        .i_mem_clear   (i_mem_clear),
        .i_addr        (pc_q),
        .o_instruction (o_instruction),
        .o_mem_full    (o_mem_full),
        .o_mem_empty   (o_mem_empty)
    );

    assign o_next_seq_pc = pc_q + PC_SIZE'(4);
    assign o_halt        = (o_instruction == INSTRUCTION_SIZE'(INSTRUCTION_HALT));

    // Next-PC mux driven by the prioritised select
    always_comb begin
        w_pc_sel = select_next_pc(i_enable, i_stall, i_not_seq, o_halt);
        pc_d     = pc_q;
        case (w_pc_sel)
            PC_SEL_REDIRECT: pc_d = i_next_not_seq_pc;
            PC_SEL_SEQ:      pc_d = o_next_seq_pc;
            default:         pc_d = pc_q;
        endcase
    end

    // Program counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) pc_q <= `CLEAR(PC_SIZE);
        else         pc_q <= pc_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        stall;
    logic        not_seq;
    logic [31:0] target;
    logic        mem_write;
    logic [7:0]  mem_data;
    logic        mem_clear;
    logic [31:0] next_seq_pc;
    logic [31:0] instruction;
    logic        halt;
    logic        mem_full;
    logic        mem_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .PC_SIZE           (32),
        .INSTRUCTION_SIZE  (32),
        .MEM_SIZE_IN_WORDS (256)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_enable          (enable),
        .i_stall           (stall),
        .i_not_seq         (not_seq),
        .i_next_not_seq_pc (target),
        .i_mem_write       (mem_write),
        .i_mem_data        (mem_data),
        .i_mem_clear       (mem_clear),
        .o_next_seq_pc     (next_seq_pc),
        .o_instruction     (instruction),
        .o_halt            (halt),
        .o_mem_full        (mem_full),
        .o_mem_empty       (mem_empty)
    );

    typedef struct {
        logic        en;
        logic        st;
        logic        ns;
        logic [31:0] tgt;
        logic [31:0] exp_nsp;
        logic [31:0] exp_instr;
        logic        exp_halt;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        mem_write = 1'b1;
        mem_data  = b;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] t);
        enable  = 1'b1;
        not_seq = 1'b1;
        target  = t;
        tick();
        enable  = 1'b0;
        not_seq = 1'b0;
    endtask

    initial begin
        //           en    st    ns    target        nsp           instr          halt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h2002_0007, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'hFFFF_FFFF, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'hFFFF_FFFF, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h0,        32'h4,        32'h2001_0005, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h40,       32'h4,        32'h2001_0005, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h40,       32'h44,       32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h4,        32'h44,       32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h44,       32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h4,        32'h8,        32'h2002_0007, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h8,        32'h2002_0007, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'hFFFF_FFFF, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFF, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h2,        32'h6,        32'h0005_2002, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hA,        32'h0007_FFFF, 1'b0};

        rst = 1'b1; enable = 1'b0; stall = 1'b0; not_seq = 1'b0; target = '0;
        mem_write = 1'b0; mem_data = '0; mem_clear = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("reset_nsp", next_seq_pc, 32'h4);
        check("reset_empty", {31'b0, mem_empty}, 32'h1);
        check("reset_full", {31'b0, mem_full}, 32'h0);

        // Clear, then load two words followed by HALT
        mem_clear = 1'b1;
        tick();
        mem_clear = 1'b0;
        check("clear_instr", instruction, 32'hFFFF_FFFF);
        check("clear_halt", {31'b0, halt}, 32'h1);
        load_byte(8'h20);
        check("first_write_empty", {31'b0, mem_empty}, 32'h0);
        load_byte(8'h01); load_byte(8'h00); load_byte(8'h05);
        load_byte(8'h20); load_byte(8'h02); load_byte(8'h00); load_byte(8'h07);
        for (int i = 0; i < 4; i++) load_byte(8'hFF);
        check("load_instr0", instruction, 32'h2001_0005);
        check("load_nsp0", next_seq_pc, 32'h4);

        // Table-driven PC selection
        for (int i = 0; i < 14; i++) begin
            enable  = vecs[i].en;
            stall   = vecs[i].st;
            not_seq = vecs[i].ns;
            target  = vecs[i].tgt;
            tick();
            check($sformatf("vec%0d_nsp", i), next_seq_pc, vecs[i].exp_nsp);
            check($sformatf("vec%0d_instr", i), instruction, vecs[i].exp_instr);
            check($sformatf("vec%0d_halt", i), {31'b0, halt}, {31'b0, vecs[i].exp_halt});
        end
        stall = 1'b0; not_seq = 1'b0;

        // HALT sticks for many cycles, then a redirect releases it
        redirect(32'h8);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("halt_hold%0d_nsp", i), next_seq_pc, 32'hC);
            check($sformatf("halt_hold%0d_halt", i), {31'b0, halt}, 32'h1);
        end
        not_seq = 1'b1; target = 32'h0;
        tick();
        not_seq = 1'b0;
        check("halt_release_nsp", next_seq_pc, 32'h4);
        check("halt_release_halt", {31'b0, halt}, 32'h0);

        // Loader writes while enabled are dropped; pointer stays at byte 12
        redirect(32'hC);
        enable = 1'b1;
        load_byte(8'h11);
        check("enabled_write_instr", instruction, 32'hFFFF_FFFF);
        enable = 1'b0;
        load_byte(8'hAB);
        check("ptr_unchanged_instr", instruction, 32'hABFF_FFFF);

        // Reset mid-load rewinds pointer, keeps bytes
        mem_clear = 1'b1;
        tick();
        mem_clear = 1'b0;
        load_byte(8'h12); load_byte(8'h34); load_byte(8'h56);
        load_byte(8'h78); load_byte(8'h9A); load_byte(8'hBC);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midload_reset_nsp", next_seq_pc, 32'h4);
        check("midload_reset_empty", {31'b0, mem_empty}, 32'h1);
        check("midload_reset_instr", instruction, 32'h1234_5678);

        // Clear wins over a simultaneous write
        mem_clear = 1'b1;
        mem_write = 1'b1;
        mem_data  = 8'h00;
        tick();
        mem_clear = 1'b0;
        mem_write = 1'b0;
        check("clear_vs_write_instr", instruction, 32'hFFFF_FFFF);
        check("clear_vs_write_empty", {31'b0, mem_empty}, 32'h1);

        // Fill the whole memory, then overflow
        for (int i = 0; i < 1024; i++) begin
            load_byte(8'(i));
            if (i == 1022) check("full_before_last", {31'b0, mem_full}, 32'h0);
        end
        check("full_after_1024", {31'b0, mem_full}, 32'h1);
        load_byte(8'h00);
        check("full_after_1025", {31'b0, mem_full}, 32'h1);
        redirect(32'h3FC);
        check("last_word", instruction, 32'hFCFD_FEFF);
        redirect(32'h3FB);
        check("inrange_edge", instruction, 32'hFBFC_FDFE);
        redirect(32'h3FD);
        check("outrange_3fd", instruction, 32'hFFFF_FFFF);
        redirect(32'h400);
        check("outrange_400", instruction, 32'hFFFF_FFFF);
        check("outrange_halt", {31'b0, halt}, 32'h1);

        // Clear drops full
        mem_clear = 1'b1;
        tick();
        mem_clear = 1'b0;
        check("clear_full", {31'b0, mem_full}, 32'h0);
        check("clear_empty", {31'b0, mem_empty}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter, a byte-addressed instruction memory loaded by the debug unit, and next-PC selection (sequential, redirect, stall, halt). It presents the fetched instruction and PC+4 combinationally so IF/ID latches them on the next enabled edge.

## Interface
- `PC_SIZE`, 32, PC and address width.
- `INSTRUCTION_SIZE`, 32, instruction width (fixed at 4 bytes).
- `MEM_SIZE_IN_WORDS`, 256, instruction memory depth in words; byte capacity `4*MEM_SIZE_IN_WORDS`.

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  pipeline advance (run or debug step); 0 freezes the PC and opens the loader port.
- `i_stall`  in  1  hazard-unit stall; holds the PC.
- `i_not_seq`  in  1  redirect request (taken branch or jump resolved in ID).
- `i_next_not_seq_pc`  in  PC_SIZE  redirect target.
- `i_mem_write`  in  1  loader byte-write strobe.
- `i_mem_data`  in  8  loader byte.
- `i_mem_clear`  in  1  fill memory with 0xFF and rewind the write pointer.
- `o_next_seq_pc`  out  PC_SIZE  PC+4, combinational from the PC.
- `o_instruction`  out  INSTRUCTION_SIZE  instruction at the PC, combinational.
- `o_halt`  out  1  `o_instruction` equals HALT.
- `o_mem_full`  out  1  write pointer equals byte capacity.
- `o_mem_empty`  out  1  write pointer equals 0.

## Operation
- HALT = 32'hFFFF_FFFF.
- Fetch: `o_instruction = {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]}`. The first loaded byte is the MSB.
- If `pc+3 >= 4*MEM_SIZE_IN_WORDS`, `o_instruction` is HALT.
- PC update when `i_enable=1`, priority order:
  - `i_stall`: hold.
  - `i_not_seq`: PC becomes `i_next_not_seq_pc`.
  - `o_halt`: hold.
  - Otherwise PC becomes PC+4, modulo 2^PC_SIZE.
- Redirect beats halt: an older branch in ID overrides a fetched HALT. Stall beats redirect.
- `i_enable=0`: PC holds and all PC inputs are ignored.
- Loader writes:
  - Accepted only when `i_enable=0` and `o_mem_full=0`.
  - Byte goes to `mem[wr_ptr]`, then `wr_ptr++`.
  - Writes while full or enabled are dropped. No pointer change, no memory change.
- `i_mem_clear`:
  - Honoured regardless of `i_enable`.
  - All bytes become 0xFF and `wr_ptr` becomes 0 in one cycle.
  - Wins over a simultaneous `i_mem_write`.
- `i_reset`:
  - PC becomes 0 and `wr_ptr` becomes 0.
  - Memory contents are retained, so a program survives reset.
  - Reset wins over every other input in the same cycle.
  - A reset mid-load rewinds the pointer; bytes already written remain.
- `wr_ptr` width is `clog2(4*MEM_SIZE_IN_WORDS)+1`, so full is representable without wrap.

## Timing
- Reset values:
  - PC = 0 and `o_next_seq_pc` = 4.
  - `o_mem_empty` = 1 and `o_mem_full` = 0.
  - `o_instruction` and `o_halt` reflect memory at address 0.
- PC changes one edge after the qualifying inputs. Instruction and PC+4 are valid in the same cycle, with zero-cycle read latency.
- Loader byte is visible on a fetch read the cycle after its write edge.
- Full is asserted the cycle after the `4*MEM_SIZE_IN_WORDS`-th accepted write. Empty is deasserted the cycle after the first accepted write.
- After HALT is fetched, the PC stays constant indefinitely until redirect or reset; `o_halt` stays 1.

## Structure
- Shared header (alongside the existing pipeline `.vh` defaults):
  - `DEFAULT_PC_SIZE`
  - `DEFAULT_INSTRUCTION_SIZE`
  - `DEFAULT_INSTRUCTION_MEM_WORDS`
  - `INSTRUCTION_HALT`
  - the `CLEAR(n)` macro
- One sub-module, `instruction_memory`: byte array, write pointer, clear, full/empty, and 4-byte combinational read with out-of-range HALT.
- PC register and next-PC priority logic stay in `instruction_fetch`.

## Test plan
- Reset, then clear, then load 8 bytes 20 01 00 05 / 20 02 00 07 with `i_enable=0` -> `o_mem_empty=0`, then enable. Required response:
  - `o_instruction` = 32'h2001_0005, `o_next_seq_pc` = 4.
  - Next edge: `o_instruction` = 32'h2002_0007, `o_next_seq_pc` = 8.
- Load the two words above followed by HALT and run -> PC sticks at 8 with `o_halt=1` for 10 cycles. Then pulse `i_not_seq` with target 0 -> PC = 0 and `o_halt=0`.
- Assert `i_stall` and `i_not_seq` (target 0x40) together -> PC unchanged. Drop `i_stall` -> PC = 0x40 next edge.
- Write 1024 bytes with `MEM_SIZE_IN_WORDS=256` -> `o_mem_full=1`. 1025th write -> byte at address 0x3FF unchanged. Fetch at PC 0x400 -> HALT.
- Drive `i_mem_write` with `i_enable=1` -> pointer and memory unchanged. Drive `i_mem_clear` and `i_mem_write` in the same cycle -> all bytes 0xFF and `o_mem_empty=1`.
- Reset after 6 loaded bytes -> PC = 0 and `o_mem_empty=1`. `o_instruction` still returns the first loaded word.
